// File: rtl/lab9_soc_pkg.sv
// rtl/lab9_soc_pkg.sv - shared state encoding and sysid word addresses for lab9_soc
package lab9_soc_pkg;

  typedef enum logic [2:0] {IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, DONE} sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lab9_soc_sysid_checker.sv
// rtl/lab9_soc_sysid_checker.sv - Avalon-MM master that reads sysid ID/timestamp and flags mismatches
module lab9_soc_sysid_checker
  import lab9_soc_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1522186126,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int            CW       = $clog2(max_int(TIMEOUT_CYCLES, READ_LATENCY) + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam bit            NO_LAT   = (READ_LATENCY == 0);

  sysid_state_t  state;
  logic [CW-1:0] cnt;
  logic          auto_pend;
  logic          id_bad;
  logic          ts_bad;
  logic          accept;

  assign accept = avm_read && !avm_waitrequest;

  // cnt is shared: stall cycles in REQ_x, latency cycles in LAT_x
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      auto_pend   <= AUTO_START;
      id_bad      <= 1'b0;
      ts_bad      <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      auto_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (start || auto_pend) begin
            state       <= REQ_ID;
            cnt         <= '0;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_bad      <= 1'b0;
            ts_bad      <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end
        REQ_ID, REQ_TS: begin
          if (accept) begin
            cnt <= '0;
            if (!NO_LAT) begin
              avm_read <= 1'b0;
              state    <= (state == REQ_ID) ? LAT_ID : LAT_TS;
            end else if (state == REQ_ID) begin
              id_value    <= avm_readdata;
              id_bad      <= (avm_readdata != EXPECTED_ID);
              avm_address <= SYSID_ADDR_TS;
              state       <= REQ_TS;
            end else begin
              ts_value <= avm_readdata;
              ts_bad   <= (avm_readdata != EXPECTED_TS);
              avm_read <= 1'b0;
              busy     <= 1'b0;
              state    <= DONE;
            end
          end else if (cnt == TO_LAST) begin
            avm_read <= 1'b0;
            timeout  <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LAT_ID: begin
          if (cnt == LAT_LAST) begin
            id_value    <= avm_readdata;
            id_bad      <= (avm_readdata != EXPECTED_ID);
            cnt         <= '0;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
            state       <= REQ_TS;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LAT_TS: begin
          if (cnt == LAT_LAST) begin
            ts_value <= avm_readdata;
            ts_bad   <= (avm_readdata != EXPECTED_TS);
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done        <= 1'b1;
          id_mismatch <= id_bad;
          ts_mismatch <= ts_bad;
          pass        <= !timeout && !id_bad && !ts_bad;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
